cell_editor: RTL and testbench

CELL_EDITOR -- requirements
Module: cell_editor

---
 rtl/gol_pkg.sv | 17 +
 rtl/addr_sweep.sv | 29 ++
 rtl/cell_editor.sv | 144 ++++++++++++++
 tb/tb_cell_editor.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/gol_pkg.sv
// Shared Game-of-Life constants: board geometry, RAM address width and the
// cell-editor state encoding.
package gol_pkg;

  localparam int BOARD_N = 800;
  localparam int BOARD_M = 600;
  localparam int ADDR_W  = 24;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WAIT,
    S_WRITE,
    S_WIPE
  } edit_state_t;

endpackage

// File: rtl/addr_sweep.sv
// Linear address counter for the board wipe: restarts at 0 on start, steps on
// enable and parks on limit, where last is raised.
module addr_sweep #(
  parameter int W = 24
) (
  input  logic         clk_vga,
  input  logic         reset_btn,
  input  logic         start,
  input  logic         enable,
  input  logic [W-1:0] limit,
  output logic [W-1:0] addr,
  output logic         last
);

  logic [W-1:0] r_addr;

  always_ff @(posedge clk_vga or posedge reset_btn) begin
    if (reset_btn)
      r_addr <= '0;
    else if (start)
      r_addr <= '0;
    else if (enable && !last)
      r_addr <= r_addr + W'(1);
  end

  assign addr = r_addr;
  assign last = (r_addr == limit);

endmodule

// File: rtl/cell_editor.sv
// Board editor: toggles the cell under the cursor by read-modify-write, or
// clears the whole board with a one-address-per-cycle write sweep.
module cell_editor
  import gol_pkg::*;
#(
  parameter int P_N    = gol_pkg::BOARD_N,
  parameter int P_M    = gol_pkg::BOARD_M,
  parameter int ADDR_W = gol_pkg::ADDR_W,
  parameter int RD_LAT = 2
) (
  input  logic              clk_vga,
  input  logic              reset_btn,
  input  logic              edit_en,
  input  logic              modify,
  input  logic              wipe,
  input  logic [ADDR_W-1:0] cursor_pos,
  input  logic              ram_q,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_rden,
  output logic              ram_wren,
  output logic              ram_wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [15:0]       edit_count
);

  localparam logic [ADDR_W-1:0] L_CELLS = ADDR_W'(P_N * P_M);
  localparam logic [ADDR_W-1:0] L_LAST  = ADDR_W'(P_N * P_M - 1);
  localparam logic [2:0]        L_WAIT_END = 3'(RD_LAT - 1);

  edit_state_t       r_state;
  edit_state_t       w_next;
  logic [ADDR_W-1:0] r_cell;
  logic [2:0]        r_wait_cnt;
  logic [ADDR_W-1:0] r_ram_addr;
  logic              r_rden;
  logic              r_wren;
  logic              r_wdata;
  logic              r_busy;
  logic              r_done;
  logic              r_err;
  logic [15:0]       r_edit_count;

  logic              w_in_range;
  logic              w_sweep_start;
  logic              w_sweep_en;
  logic              w_sweep_last;
  logic [ADDR_W-1:0] w_sweep_addr;
  logic [ADDR_W-1:0] w_wipe_addr_nxt;

  assign w_in_range      = (cursor_pos < L_CELLS);
  assign w_sweep_start   = (r_state == S_IDLE) && (w_next == S_WIPE);
  assign w_sweep_en      = (r_state == S_WIPE);
  assign w_wipe_addr_nxt = (r_state == S_WIPE) ? (w_sweep_addr + ADDR_W'(1)) : '0;

  addr_sweep #(.W(ADDR_W)) u_sweep (
    .clk_vga   (clk_vga),
    .reset_btn (reset_btn),
    .start     (w_sweep_start),
    .enable    (w_sweep_en),
    .limit     (L_LAST),
    .addr      (w_sweep_addr),
    .last      (w_sweep_last)
  );

  always_ff @(posedge clk_vga or posedge reset_btn) begin
    if (reset_btn)
      r_state <= S_IDLE;
    else
      r_state <= w_next;
  end

  // Dropping edit_en abandons any operation in flight, overriding the normal flow.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (edit_en && wipe)
          w_next = S_WIPE;
        else if (edit_en && modify && w_in_range)
          w_next = S_READ;
      end
      S_READ:  w_next = S_WAIT;
      S_WAIT:  if (r_wait_cnt == L_WAIT_END) w_next = S_WRITE;
      S_WRITE: w_next = S_IDLE;
      S_WIPE:  if (w_sweep_last) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    if (r_state != S_IDLE && !edit_en)
      w_next = S_IDLE;
  end

  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk_vga or posedge reset_btn) begin
    if (reset_btn) begin
      r_cell       <= '0;
      r_wait_cnt   <= '0;
      r_ram_addr   <= '0;
      r_rden       <= 1'b0;
      r_wren       <= 1'b0;
      r_wdata      <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      r_edit_count <= '0;
    end else begin
      r_rden     <= (w_next == S_READ);
      r_wren     <= (w_next == S_WRITE) || (w_next == S_WIPE);
      r_busy     <= (w_next != S_IDLE);
      r_done     <= (w_next == S_WRITE) ||
                    ((w_next == S_WIPE) && (w_wipe_addr_nxt == L_LAST));
      r_err      <= (r_state == S_IDLE) && edit_en && !wipe && modify && !w_in_range;
      r_wait_cnt <= (r_state == S_WAIT) ? (r_wait_cnt + 3'd1) : 3'd0;

      if (r_state == S_IDLE && w_next == S_READ)
        r_cell <= cursor_pos;

      case (w_next)
        S_READ:  r_ram_addr <= (r_state == S_IDLE) ? cursor_pos : r_cell;
        S_WRITE: r_ram_addr <= r_cell;
        S_WIPE:  r_ram_addr <= w_wipe_addr_nxt;
        default: r_ram_addr <= r_ram_addr;
      endcase

      if (w_next == S_WRITE) begin
        r_wdata      <= ~ram_q;
        r_edit_count <= r_edit_count + 16'd1;
      end else if (w_next == S_WIPE) begin
        r_wdata <= 1'b0;
      end
    end
  end

  assign ram_addr   = r_ram_addr;
  assign ram_rden   = r_rden;
  assign ram_wren   = r_wren;
  assign ram_wdata  = r_wdata;
  assign busy       = r_busy;
  assign done       = r_done;
  assign err        = r_err;
  assign edit_count = r_edit_count;

endmodule

// File: tb/tb_cell_editor.sv
// Randomized bench for cell_editor on a reduced board, with a latency-accurate
// RAM and a cell-array reference model of what the board should contain.
module tb_cell_editor;

  localparam int N      = 80;
  localparam int M      = 60;
  localparam int CELLS  = N * M;
  localparam int AW     = 24;
  localparam int RD_LAT = 2;
  localparam int WR_K   = RD_LAT + 2;

  logic          clk_vga = 1'b0;
  logic          reset_btn;
  logic          edit_en;
  logic          modify;
  logic          wipe;
  logic [AW-1:0] cursor_pos;
  logic          ram_q;
  logic [AW-1:0] ram_addr;
  logic          ram_rden;
  logic          ram_wren;
  logic          ram_wdata;
  logic          busy;
  logic          done;
  logic          err;
  logic [15:0]   edit_count;

  int testCount = 0;
  int failCount = 0;

  bit       initCells [CELLS];
  bit       expCells  [CELLS];
  logic     memArr    [CELLS];
  logic [RD_LAT-1:0] rdPipe;
  bit       loadMem;
  int       expCount;

  always #10 clk_vga = ~clk_vga;

  cell_editor #(.P_N(N), .P_M(M), .ADDR_W(AW), .RD_LAT(RD_LAT)) dut (
    .clk_vga    (clk_vga),
    .reset_btn  (reset_btn),
    .edit_en    (edit_en),
    .modify     (modify),
    .wipe       (wipe),
    .cursor_pos (cursor_pos),
    .ram_q      (ram_q),
    .ram_addr   (ram_addr),
    .ram_rden   (ram_rden),
    .ram_wren   (ram_wren),
    .ram_wdata  (ram_wdata),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .edit_count (edit_count)
  );

  // Board RAM: writes land on the edge, reads appear RD_LAT cycles after rden.
  always @(posedge clk_vga) begin
    if (loadMem) begin
      for (int i = 0; i < CELLS; i++) memArr[i] <= initCells[i];
    end else if (ram_wren && ram_addr < AW'(CELLS)) begin
      memArr[ram_addr] <= ram_wdata;
    end
    rdPipe[0] <= (ram_addr < AW'(CELLS)) ? memArr[ram_addr] : 1'b0;
    for (int i = 1; i < RD_LAT; i++) rdPipe[i] <= rdPipe[i-1];
  end
  assign ram_q = rdPipe[RD_LAT-1];

  // Single point of comparison and failure reporting.
  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] expv);
    testCount++;
    if (act !== expv) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, act, expv);
    end
  endtask

  function automatic logic [4:0] status();
    return {busy, ram_rden, ram_wren, done, err};
  endfunction

  task automatic doToggle(input int c, input bit interfere);
    logic expW;
    logic [4:0] expSt;
    expW = ~expCells[c];
    @(negedge clk_vga);
    cursor_pos = AW'(c); modify = 1'b1;
    for (int k = 1; k <= WR_K + 1; k++) begin
      @(negedge clk_vga);
      modify = 1'b0;
      expSt = {k <= WR_K, k == 1, k == WR_K, k == WR_K, 1'b0};
      checkOutput($sformatf("togSt%0d", k), 32'(status()), 32'(expSt));
      if (k == 1) checkOutput("togRdAddr", 32'(ram_addr), 32'(c));
      if (k == WR_K) begin
        checkOutput("togWrAddr", 32'(ram_addr), 32'(c));
        checkOutput("togWdata", 32'(ram_wdata), 32'(expW));
        checkOutput("togCount", 32'(edit_count), 32'((expCount + 1) % 65536));
      end
      if (interfere && k == 2) begin
        cursor_pos = AW'($urandom_range(0, CELLS - 1));
        modify = 1'b1;
        wipe = $urandom_range(0, 1) == 1;
      end else begin
        wipe = 1'b0;
      end
    end
    expCells[c] = expW;
    expCount = (expCount + 1) % 65536;
  endtask

  task automatic doBadModify(input int c);
    @(negedge clk_vga);
    cursor_pos = AW'(c); modify = 1'b1;
    @(negedge clk_vga);
    modify = 1'b0;
    checkOutput("errPulse", 32'(status()), 32'(5'b00001));
    @(negedge clk_vga);
    checkOutput("errGone", 32'(status()), 32'(5'b00000));
    checkOutput("errCount", 32'(edit_count), 32'(expCount));
  endtask

  task automatic doDisabled();
    @(negedge clk_vga);
    edit_en = 1'b0;
    cursor_pos = AW'($urandom_range(0, CELLS - 1));
    modify = 1'b1; wipe = $urandom_range(0, 1) == 1;
    @(negedge clk_vga);
    modify = 1'b0; wipe = 1'b0;
    for (int k = 0; k < 3; k++) begin
      checkOutput("disabledIdle", 32'(status()), 32'(5'b00000));
      @(negedge clk_vga);
    end
    edit_en = 1'b1;
  endtask

  task automatic doWipe(input bit alsoModify, input int abortAt);
    int bad;
    int lastK;
    bit ok;
    bad = 0;
    lastK = CELLS - 1;
    @(negedge clk_vga);
    wipe = 1'b1; modify = alsoModify;
    cursor_pos = AW'($urandom_range(0, CELLS - 1));
    for (int k = 0; k < CELLS; k++) begin
      @(negedge clk_vga);
      wipe = 1'b0; modify = 1'b0;
      ok = busy && ram_wren && !ram_rden && !err && (ram_addr == AW'(k)) &&
           (ram_wdata == 1'b0) && (done == (k == CELLS - 1));
      if (!ok) bad++;
      if (k == abortAt) begin
        lastK = k;
        edit_en = 1'b0;
        break;
      end
    end
    checkOutput("wipeSweepBadCycles", 32'(bad), 32'd0);
    @(negedge clk_vga);
    checkOutput("wipeAfter", 32'(status()), 32'(5'b00000));
    for (int i = 0; i <= lastK; i++) expCells[i] = 1'b0;
    edit_en = 1'b1;
    checkOutput("wipeCount", 32'(edit_count), 32'(expCount));
  endtask

  task automatic checkRamImage(input string tag);
    int diff;
    diff = 0;
    for (int i = 0; i < CELLS; i++) if (memArr[i] !== expCells[i]) diff++;
    checkOutput(tag, 32'(diff), 32'd0);
  endtask

  task automatic doResetInWait();
    @(negedge clk_vga);
    cursor_pos = AW'($urandom_range(0, CELLS - 1)); modify = 1'b1;
    @(negedge clk_vga);
    modify = 1'b0;
    @(negedge clk_vga);
    #2 reset_btn = 1'b1;
    #1;
    checkOutput("rstMidSt", 32'(status()), 32'(5'b00000));
    checkOutput("rstMidAddr", 32'(ram_addr), 32'd0);
    checkOutput("rstMidWdata", 32'(ram_wdata), 32'd0);
    checkOutput("rstMidCount", 32'(edit_count), 32'd0);
    expCount = 0;
    @(negedge clk_vga);
    reset_btn = 1'b0;
    @(negedge clk_vga);
    checkOutput("postRstIdle", 32'(status()), 32'(5'b00000));
  endtask

  task automatic applyStimulus();
    int op;
    int c;
    for (int n = 0; n < 60; n++) begin
      op = $urandom_range(0, 9);
      if (op <= 5) begin
        c = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 7) : $urandom_range(0, CELLS - 1);
        doToggle(c, $urandom_range(0, 3) == 0);
      end else if (op == 6) begin
        doBadModify($urandom_range(CELLS, CELLS + 5000));
      end else if (op == 7) begin
        doDisabled();
      end else begin
        c = $urandom_range(0, 7);
        doToggle(c, 1'b0);
        doToggle(c, 1'b0);
      end
    end
  endtask

  initial begin
    reset_btn = 1'b1; edit_en = 1'b0; modify = 1'b0; wipe = 1'b0;
    cursor_pos = '0; loadMem = 1'b1; expCount = 0;
    for (int i = 0; i < CELLS; i++) begin
      initCells[i] = $urandom_range(0, 1) == 1;
      expCells[i]  = initCells[i];
    end
    repeat (3) @(negedge clk_vga);
    checkOutput("rstSt", 32'(status()), 32'(5'b00000));
    checkOutput("rstAddr", 32'(ram_addr), 32'd0);
    checkOutput("rstWdata", 32'(ram_wdata), 32'd0);
    checkOutput("rstCount", 32'(edit_count), 32'd0);
    loadMem = 1'b0; reset_btn = 1'b0; edit_en = 1'b1;
    @(negedge clk_vga);

    doToggle(CELLS / 2 + N / 2, 1'b0);
    doToggle(CELLS / 2 + N / 2, 1'b0);
    doToggle(0, 1'b0);
    doToggle(CELLS - 1, 1'b0);
    doBadModify(CELLS);
    doBadModify(CELLS + 1);
    checkRamImage("ramAfterToggles");

    applyStimulus();
    checkRamImage("ramAfterRandom");

    doWipe(1'b1, -1);
    checkRamImage("ramAfterWipe");
    for (int i = 0; i < 4; i++) doToggle($urandom_range(0, CELLS - 1), 1'b0);
    doWipe(1'b0, 1000);
    checkRamImage("ramAfterAbort");
    doToggle(2000, 1'b0);
    doWipe(1'b0, -1);
    checkRamImage("ramAfterRestart");

    doResetInWait();
    doToggle($urandom_range(0, CELLS - 1), 1'b0);
    checkRamImage("ramFinal");

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
